// File: rtl/esn_sram_loader.sv
// esn_sram_loader: streams host words into the ESN off-chip SRAM regions, then enables the reservoir run
// Ports:
//   clk, nrst          clock and synchronous active-high reset
//   start, stop        one-cycle pulses: begin a load / abort a load or end a run
//   s_valid, s_data    incoming word stream; s_ready high while loading
//   SEL_SRAM_input     region select (0 none, 1 X, 2 W, 3 Win, 4 Winb, 5 Wout)
//   addr_inSRAM_offchip, Data_in  write address and data
//   EN_system_n        active-low system enable, low during RUN
//   busy, load_done, aborted      status: loading/gap, RUN entry pulse, sticky abort flag
module esn_sram_loader #(
   parameter int bit_length = 32,
   parameter int addr_length_heap = 10,
   parameter int node_num = 1000,
   parameter logic [4:0] LOAD_MASK = 5'b11111
) (
   input  logic clk,
   input  logic nrst,
   input  logic start,
   input  logic stop,
   input  logic s_valid,
   input  logic [bit_length-1:0] s_data,
   output logic s_ready,
   output logic [2:0] SEL_SRAM_input,
   output logic [addr_length_heap-1:0] addr_inSRAM_offchip,
   output logic [bit_length-1:0] Data_in,
   output logic EN_system_n,
   output logic busy,
   output logic load_done,
   output logic aborted
);
   typedef enum logic [1:0] {IDLE, LOAD, GAP, RUN} state_t;
   localparam logic [addr_length_heap-1:0] last_idx = addr_length_heap'(node_num - 1);
   state_t state;
   logic [2:0] region;
   logic [2:0] nxt;
   logic [addr_length_heap-1:0] idx;
   // lowest enabled region at or above from; 5 means no region left
   function automatic logic [2:0] next_region(input logic [3:0] from);
      next_region = 3'd5;
      for (int i = 4; i >= 0; i--)
         if (LOAD_MASK[i] && 4'(i) >= from) next_region = 3'(i);
   endfunction
   assign nxt = next_region({1'b0, region} + 4'd1);
   assign s_ready = state == LOAD;
   assign busy = state == LOAD || state == GAP;
   always_ff @(posedge clk) begin
      if (nrst) begin
         state <= IDLE;
         region <= 3'd0;
         idx <= '0;
         SEL_SRAM_input <= 3'd0;
         addr_inSRAM_offchip <= '0;
         Data_in <= '0;
         EN_system_n <= 1'b1;
         load_done <= 1'b0;
         aborted <= 1'b0;
      end else begin
         SEL_SRAM_input <= 3'd0;
         load_done <= 1'b0;
         case (state)
            IDLE: if (start && !stop) begin
               aborted <= 1'b0;
               idx <= '0;
               region <= next_region(4'd0);
               state <= LOAD_MASK == 5'd0 ? GAP : LOAD;
            end
            LOAD: if (stop) begin
               state <= IDLE;
               aborted <= 1'b1;
            end else if (s_valid) begin
               SEL_SRAM_input <= region + 3'd1;
               addr_inSRAM_offchip <= idx;
               Data_in <= s_data;
               idx <= idx == last_idx ? '0 : idx + 1'b1;
               // region wrap: last word of the last enabled region ends the load
               if (idx == last_idx) begin
                  if (nxt == 3'd5) state <= GAP;
                  else region <= nxt;
               end
            end
            GAP: begin
               state <= RUN;
               load_done <= 1'b1;
               EN_system_n <= 1'b0;
            end
            RUN: if (stop) begin
               state <= IDLE;
               EN_system_n <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_esn_sram_loader.sv
// tb_esn_sram_loader: three loaders (full, sparse, empty mask) checked against a count-based model
module tb_esn_sram_loader;
   localparam int BL = 32;
   localparam int AL = 10;
   localparam int N = 4;
   localparam logic [4:0] MASKS [3] = '{5'b11111, 5'b10010, 5'b00000};
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] start_v = '0, stop_v = '0, valid_v = '0;
   logic [BL-1:0] sd [3];
   wire [2:0] ready_v, en_v, done_v, busy_v, ab_v;
   wire [2:0] sel_o [3];
   wire [AL-1:0] addr_o [3];
   wire [BL-1:0] dat_o [3];
   int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, fall_cyc = 0;
   int done_cnt = 0;
   logic prev_en = 1'b1;
   logic [44:0] q0[$], q1[$];
   int ph [3], cnt [3];
   logic [2:0] e_sel [3];
   logic [AL-1:0] e_addr [3];
   logic [BL-1:0] e_data [3];
   logic e_en [3], e_ld [3], e_ab [3];

   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < 3; g++) begin : g_dut
      esn_sram_loader #(.bit_length(BL), .addr_length_heap(AL), .node_num(N), .LOAD_MASK(MASKS[g])) u_dut (
         .clk(clk), .nrst(rst), .start(start_v[g]), .stop(stop_v[g]), .s_valid(valid_v[g]),
         .s_data(sd[g]), .s_ready(ready_v[g]), .SEL_SRAM_input(sel_o[g]),
         .addr_inSRAM_offchip(addr_o[g]), .Data_in(dat_o[g]), .EN_system_n(en_v[g]),
         .busy(busy_v[g]), .load_done(done_v[g]), .aborted(ab_v[g]));
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int pop(input logic [4:0] m);
      int p = 0;
      for (int i = 0; i < 5; i++) p += int'(m[i]);
      return p;
   endfunction

   // region code of the c-th word of a load: the (c/N)-th enabled region, numbered from 1
   function automatic logic [2:0] code(input logic [4:0] m, input int c);
      int n = c / N;
      for (int i = 0; i < 5; i++)
         if (m[i]) begin
            if (n == 0) return 3'(i + 1);
            n--;
         end
      return 3'd0;
   endfunction

   // model update on each edge, then compare all three DUTs just after it
   always begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            ph[k] = 0; cnt[k] = 0; e_sel[k] = 0; e_addr[k] = 0; e_data[k] = 0;
            e_en[k] = 1; e_ld[k] = 0; e_ab[k] = 0;
         end else begin
            e_ld[k] = 0;
            e_sel[k] = 0;
            case (ph[k])
               0: if (start_v[k] && !stop_v[k]) begin
                  e_ab[k] = 0; cnt[k] = 0; ph[k] = pop(MASKS[k]) == 0 ? 2 : 1;
               end
               1: if (stop_v[k]) begin
                  ph[k] = 0; e_ab[k] = 1;
               end else if (valid_v[k]) begin
                  e_sel[k] = code(MASKS[k], cnt[k]);
                  e_addr[k] = AL'(cnt[k] % N);
                  e_data[k] = sd[k];
                  cnt[k]++;
                  if (cnt[k] == N * pop(MASKS[k])) begin
                     ph[k] = 2;
                     if (k == 0) acc_cyc = cyc;
                  end
               end
               2: begin ph[k] = 3; e_ld[k] = 1; e_en[k] = 0; end
               default: if (stop_v[k]) begin ph[k] = 0; e_en[k] = 1; end
            endcase
         end
      end
      cyc++;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("sel%0d", k), sel_o[k], e_sel[k]);
         chk($sformatf("addr%0d", k), addr_o[k], e_addr[k]);
         chk($sformatf("data%0d", k), dat_o[k], e_data[k]);
         chk($sformatf("en_n%0d", k), en_v[k], e_en[k]);
         chk($sformatf("load_done%0d", k), done_v[k], e_ld[k]);
         chk($sformatf("aborted%0d", k), ab_v[k], e_ab[k]);
         chk($sformatf("ready%0d", k), ready_v[k], ph[k] == 1);
         chk($sformatf("busy%0d", k), busy_v[k], ph[k] == 1 || ph[k] == 2);
      end
      if (sel_o[0] != 0) q0.push_back({sel_o[0], addr_o[0], dat_o[0]});
      if (sel_o[1] != 0) q1.push_back({sel_o[1], addr_o[1], dat_o[1]});
      if (done_v[0]) done_cnt++;
      if (prev_en && !en_v[0]) fall_cyc = cyc;
      prev_en = en_v[0];
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      int rdy;
      for (int k = 0; k < 3; k++) sd[k] = '0;
      tick(2);
      chk("rst_en_n", en_v[0], 1'b1);
      chk("rst_sel", sel_o[0], 3'd0);
      rst = 1'b0;
      tick();
      // full mask, continuous stream 0x100..0x113
      q0.delete();
      done_cnt = 0;
      start_v[0] = 1; tick(); start_v[0] = 0;
      for (int i = 0; i < 20; i++) begin
         valid_v[0] = 1; sd[0] = 32'h100 + i; tick();
      end
      valid_v[0] = 0;
      tick(4);
      chk("t1_writes", q0.size(), 20);
      chk("t1_first", q0[0], {3'd1, 10'd0, 32'h100});
      chk("t1_w_start", q0[4], {3'd2, 10'd0, 32'h104});
      chk("t1_last", q0[19], {3'd5, 10'd3, 32'h113});
      chk("t1_en_delay", fall_cyc - acc_cyc, 2);
      chk("t1_done_pulses", done_cnt, 1);
      stop_v[0] = 1; tick(); stop_v[0] = 0;
      chk("t1_stop_en", en_v[0], 1'b1);
      // full mask, random valid and data
      q0.delete();
      start_v[0] = 1; tick(); start_v[0] = 0;
      n = 0;
      do begin
         valid_v[0] = 1'($urandom); sd[0] = $urandom; tick(); n++;
      end while (ph[0] == 1 && n < 400);
      valid_v[0] = 0;
      chk("t2_timeout", ph[0] == 1, 1'b0);
      tick(3);
      chk("t2_writes", q0.size(), 20);
      for (int i = 0; i < q0.size(); i++) chk("t2_seq", q0[i][44:32], {3'(1 + i / N), 10'(i % N)});
      stop_v[0] = 1; tick(); stop_v[0] = 0;
      // sparse mask W + Wout
      q1.delete();
      rdy = 0;
      start_v[1] = 1; tick(); start_v[1] = 0;
      for (int i = 0; i < 12; i++) begin
         rdy += int'(ready_v[1]);
         valid_v[1] = 1; sd[1] = $urandom; tick();
      end
      valid_v[1] = 0;
      tick(2);
      chk("t3_writes", q1.size(), 8);
      chk("t3_ready_cycles", rdy, 8);
      chk("t3_first", q1[0][44:32], {3'd2, 10'd0});
      chk("t3_w_end", q1[3][44:32], {3'd2, 10'd3});
      chk("t3_wout", q1[4][44:32], {3'd5, 10'd0});
      chk("t3_last", q1[7][44:32], {3'd5, 10'd3});
      stop_v[1] = 1; tick(); stop_v[1] = 0;
      // abort after 6 words, then restart
      q0.delete();
      start_v[0] = 1; tick(); start_v[0] = 0;
      for (int i = 0; i < 6; i++) begin
         valid_v[0] = 1; sd[0] = $urandom; tick();
      end
      stop_v[0] = 1; tick(); stop_v[0] = 0; valid_v[0] = 0;
      chk("t4_aborted", ab_v[0], 1'b1);
      chk("t4_sel", sel_o[0], 3'd0);
      chk("t4_en_n", en_v[0], 1'b1);
      chk("t4_writes", q0.size(), 6);
      start_v[0] = 1; tick(); start_v[0] = 0;
      chk("t4_ab_clear", ab_v[0], 1'b0);
      valid_v[0] = 1; sd[0] = 32'hABC; tick(); valid_v[0] = 0;
      chk("t4_restart", {sel_o[0], addr_o[0], dat_o[0]}, {3'd1, 10'd0, 32'hABC});
      // reset mid-load
      valid_v[0] = 1; sd[0] = $urandom; tick(2);
      rst = 1; tick(); rst = 0; valid_v[0] = 0;
      chk("t5_rst_load", {sel_o[0], addr_o[0], dat_o[0], en_v[0], busy_v[0], ready_v[0]}, {3'd0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0});
      // start and stop together in IDLE
      start_v[0] = 1; stop_v[0] = 1; tick(); start_v[0] = 0; stop_v[0] = 0;
      chk("t5_start_stop", {busy_v[0], ready_v[0]}, 2'b00);
      // reset mid-run
      start_v[0] = 1; tick(); start_v[0] = 0;
      for (int i = 0; i < 20; i++) begin
         valid_v[0] = 1; sd[0] = $urandom; tick();
      end
      valid_v[0] = 0;
      tick(3);
      chk("t5_running", en_v[0], 1'b0);
      rst = 1; tick(); rst = 0;
      chk("t5_rst_run", {en_v[0], done_v[0], busy_v[0]}, 3'b100);
      // empty mask: straight to GAP, then RUN
      start_v[2] = 1; tick(); start_v[2] = 0;
      chk("t6_gap", {busy_v[2], ready_v[2], en_v[2]}, 3'b101);
      tick();
      chk("t6_run", {done_v[2], en_v[2], busy_v[2], sel_o[2]}, {3'b100, 3'd0});
      tick();
      chk("t6_done_once", done_v[2], 1'b0);
      stop_v[2] = 1; tick(); stop_v[2] = 0;
      chk("t6_stop", en_v[2], 1'b1);
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
